// File: rtl/w0rm_core_defs_pkg.sv
// Shared W0RM core definitions: reset PC default, instruction step and width helpers.
package w0rm_core_defs;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int inst_bytes(input int inst_width);
    return inst_width / 8;
  endfunction

endpackage

// File: rtl/w0rm_fetch_slot_buffer.sv
// In-order circular buffer of fetch slots: allocate on request, fill on response, pop to decode.
module w0rm_fetch_slot_buffer
  import w0rm_core_defs::*;
#(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  localparam int PW        = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  alloc,
  input  logic [ADDR_WIDTH-1:0] alloc_pc,
  input  logic                  fill,
  input  logic [INST_WIDTH-1:0] fill_inst,
  input  logic                  pop,
  output logic [PW-1:0]         occupied,
  output logic [PW-1:0]         unfilled,
  output logic                  head_valid,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [INST_WIDTH-1:0] head_inst
);

  localparam int IW = PW - 1;

  logic [PW-1:0]         wr_ptr, rd_ptr, resp_ptr;
  logic [DEPTH-1:0]      filled_q;
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [IW-1:0]         wr_idx, rd_idx, resp_idx;

  assign wr_idx   = wr_ptr[IW-1:0];
  assign rd_idx   = rd_ptr[IW-1:0];
  assign resp_idx = resp_ptr[IW-1:0];

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign occupied   = wr_ptr - rd_ptr;
  assign unfilled   = wr_ptr - resp_ptr;
  assign head_valid = (occupied != '0) && filled_q[rd_idx];
  assign head_pc    = pc_q[rd_idx];
  assign head_inst  = inst_q[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      resp_ptr <= '0;
      filled_q <= '0;
    end else if (clear) begin
      rd_ptr   <= wr_ptr;
      resp_ptr <= wr_ptr;
      filled_q <= '0;
    end else begin
      if (alloc) begin
        wr_ptr           <= wr_ptr + PW'(1);
        filled_q[wr_idx] <= 1'b0;
      end
      if (fill) begin
        resp_ptr           <= resp_ptr + PW'(1);
        filled_q[resp_idx] <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) pc_q[wr_idx]     <= alloc_pc;
    if (fill)  inst_q[resp_idx] <= fill_inst;
  end

endmodule

// File: rtl/w0rm_core_fetch.sv
// W0RM fetch stage: sequential requests with credit, flush/redirect handling and stale-response dropping.
module w0rm_core_fetch
  import w0rm_core_defs::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_ready,
  output logic                  inst_addr_valid,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_data_valid,
  input  logic [INST_WIDTH-1:0] inst_data,
  input  logic                  branch_valid,
  input  logic                  flush_pipeline,
  input  logic                  next_pc_valid,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [INST_WIDTH-1:0] fetch_inst,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  localparam int                    PW      = clog2(DEPTH) + 1;
  localparam int                    CW      = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(inst_bytes(INST_WIDTH));

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d, used;
  logic [PW-1:0]         occupied, unfilled;
  logic                  run_q, redirect, accept, fill, pop, resp_drop, head_valid;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [INST_WIDTH-1:0] head_inst;

  assign redirect  = branch_valid & flush_pipeline;
  assign resp_drop = (drop_cnt_q != '0);
  // Responses still owed for flushed requests consume credit until they arrive.
  assign used      = CW'(occupied) + drop_cnt_q;

  assign inst_addr_valid = run_q && !redirect && (used < DEPTH_C);
  assign inst_addr       = pc_q;
  assign accept          = inst_addr_valid & mem_ready;
  assign fill            = inst_data_valid & !resp_drop & !redirect;

  assign fetch_valid = head_valid & !redirect & !resp_drop;
  assign pop         = fetch_valid & fetch_ready;
  assign fetch_inst  = fetch_valid ? head_inst : '0;
  assign fetch_pc    = fetch_valid ? head_pc   : '0;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect)
      drop_cnt_d = drop_cnt_q + CW'(unfilled) - CW'(inst_data_valid);
    else if (inst_data_valid && resp_drop)
      drop_cnt_d = drop_cnt_q - CW'(1);
  end

  // run_q holds off the first request until the clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      drop_cnt_q <= drop_cnt_d;
      if (redirect) begin
        if (next_pc_valid) pc_q <= next_pc;
      end else if (accept) begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

  w0rm_fetch_slot_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_slots (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (redirect),
    .alloc      (accept),
    .alloc_pc   (pc_q),
    .fill       (fill),
    .fill_inst  (inst_data),
    .pop        (pop),
    .occupied   (occupied),
    .unfilled   (unfilled),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst)
  );

  a_credit_bounds: assert property (@(posedge clk) disable iff (!reset_n)
    (drop_cnt_q <= DEPTH_C) && (CW'(occupied) <= DEPTH_C));

endmodule
